bisr_weight_loader: RTL
=======================

BISR_WEIGHT_LOADER -- requirements
Module: bisr_weight_loader

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, rows per tile and weights per row.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, bits per weight.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 10, weight SRAM row address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait for recovery_done after the last row.
REQ-005 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port load_req, input, 1, single-cycle request to load one tile.
REQ-008 SHALL have port tile_base, input, MEM_ADDR_WIDTH, SRAM row address of tile row 0; sampled with load_req.
REQ-009 SHALL have port abort, input, 1, cancel the current load.
REQ-010 SHALL have port mem_rd_en, output, 1, SRAM read strobe.
REQ-011 SHALL have port mem_rd_addr, output, MEM_ADDR_WIDTH, SRAM read address.
REQ-012 SHALL have port mem_rd_data, input, SYSTOLIC_SIZE*WEIGHT_WIDTH, SRAM row data; fixed 1-cycle read latency.
REQ-013 SHALL have port weight_start, output, 1, allocation-restart pulse to the BISR allocator.
REQ-014 SHALL have port weight_valid, output, 1, row qualifier to the allocator.
REQ-015 SHALL have port weights, output, SYSTOLIC_SIZE*WEIGHT_WIDTH, row to the allocator.
REQ-016 SHALL have port recovery_done, input, 1, allocator completion flag.
REQ-017 SHALL have port recovery_success, input, 1, allocator success flag.
REQ-018 SHALL have ports busy, load_done, load_ok, load_timeout, all outputs, 1 bit each: busy = not IDLE; load_done = 1-cycle completion pulse; load_ok and load_timeout = sticky status.

Function
REQ-019 SHALL implement the FSM IDLE -> START -> SEND -> WAIT -> IDLE.
REQ-020 IDLE: on load_req, latch tile_base, clear load_ok and load_timeout, go to START; load_req outside IDLE SHALL be ignored.
REQ-021 START lasts exactly 1 cycle: weight_start=1, mem_rd_en=1, mem_rd_addr=base+0; row counter cleared.
REQ-022 SEND lasts exactly SYSTOLIC_SIZE consecutive cycles with weight_valid=1, no gaps (allocator counter saturates and flags done on any gap).
REQ-023 In SEND cycle k (k=0..S-1): weights=mem_rd_data (row k, combinational pass-through); mem_rd_en=1 and mem_rd_addr=base+k+1 for k<S-1; mem_rd_en=0 for k=S-1.
REQ-024 weights SHALL be all-zero whenever weight_valid=0.
REQ-025 Address arithmetic SHALL be modulo 2^MEM_ADDR_WIDTH (wraps silently).
REQ-026 WAIT: weight_valid=0. recovery_done=1 -> load_ok<=recovery_success, pulse load_done, go to IDLE. Otherwise, when the wait counter reaches TIMEOUT_CYCLES -> load_timeout<=1, load_ok<=0, pulse load_done, go to IDLE.
REQ-027 recovery_done/recovery_success SHALL be ignored outside WAIT (stale values from the previous tile).
REQ-028 abort in START/SEND/WAIT: next cycle IDLE, all strobes 0, no load_done, status unchanged; abort has priority over all other transitions; abort in IDLE is a no-op.
REQ-029 load_req in the cycle load_done pulses SHALL be ignored (FSM still leaving WAIT).

Reset
REQ-030 rst_n low SHALL force IDLE immediately, with all outputs 0 (weights all-zero, mem_rd_addr 0) and the counters and latched base cleared; mid-load reset discards the load with no load_done.

Structure
REQ-031 The FSM state encoding and the default parameters SHALL live in the shared BISR package alongside the allocator constants.
REQ-032 No sub-module; the wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits and the row counter $clog2(SYSTOLIC_SIZE) bits.

Verification
REQ-033 S=8, tile_base=0x010, SRAM row r = {8{r+1}}, load_req @t0: weight_start @t1, valid @t2..t9 carrying rows 1..8, mem_rd_addr 0x010..0x017 @t1..t8; recovery_done=1, success=1 @t10 -> load_done @t10, load_ok=1.
REQ-034 Same load with recovery_done held 0: load_timeout=1, load_ok=0, load_done exactly 16 cycles after entering WAIT.
REQ-035 tile_base=0x3FC, S=8: read addresses 0x3FC..0x3FF then 0x000..0x003.
REQ-036 abort in SEND cycle 3: weight_valid low next cycle, busy=0, no load_done; a new load_req then produces a full clean sequence.
REQ-037 recovery_done held 1 during IDLE/START/SEND: no early completion; completion only in WAIT.
REQ-038 rst_n asserted in SEND: outputs 0 asynchronously; after release, IDLE with load_ok=0 and load_timeout=0.

Source files
------------

// File: rtl/bisr_weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bisr_weight_loader_pkg
// Purpose : Shared BISR constants: default geometry of the systolic tile,
//           weight SRAM addressing, allocator handshake timing and the
//           weight-loader FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package bisr_weight_loader_pkg;

  // Default tile geometry and SRAM addressing.
  localparam int BISR_SYSTOLIC_SIZE  = 8;
  localparam int BISR_WEIGHT_WIDTH   = 8;
  localparam int BISR_MEM_ADDR_WIDTH = 10;

  // Allocator constants: the allocator may take this many cycles after the
  // last row before it must have raised recovery_done.
  localparam int BISR_TIMEOUT_CYCLES = 16;

  // Weight-loader FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_START = 2'd1;
  localparam logic [1:0] LD_SEND  = 2'd2;
  localparam logic [1:0] LD_WAIT  = 2'd3;

endpackage : bisr_weight_loader_pkg
`default_nettype wire

// File: rtl/bisr_weight_loader.sv
`default_nettype none
// ============================================================================
// Module  : bisr_weight_loader
// Purpose : Streams one SYSTOLIC_SIZE-row weight tile from the weight SRAM
//           into the BISR allocator, then waits (bounded) for the allocator
//           to report recovery completion.
// Ports   : clk, rst_n            clock, async active-low reset
//           load_req, tile_base   start a tile load at SRAM row tile_base
//           abort                 cancel the load in progress
//           mem_rd_*              SRAM read port (1-cycle read latency)
//           weight_start/valid,   row stream to the allocator
//           weights
//           recovery_done/success allocator completion status
//           busy, load_done,      loader status (load_ok/load_timeout are
//           load_ok, load_timeout sticky until the next accepted load_req)
// Rev     : 1.0  initial release
// ============================================================================
module bisr_weight_loader
  import bisr_weight_loader_pkg::*;
#(
  parameter int SYSTOLIC_SIZE  = BISR_SYSTOLIC_SIZE,
  parameter int WEIGHT_WIDTH   = BISR_WEIGHT_WIDTH,
  parameter int MEM_ADDR_WIDTH = BISR_MEM_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = BISR_TIMEOUT_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  load_req,
  input  logic [MEM_ADDR_WIDTH-1:0]             tile_base,
  input  logic                                  abort,
  output logic                                  mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]             mem_rd_addr,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] mem_rd_data,
  output logic                                  weight_start,
  output logic                                  weight_valid,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] weights,
  input  logic                                  recovery_done,
  input  logic                                  recovery_success,
  output logic                                  busy,
  output logic                                  load_done,
  output logic                                  load_ok,
  output logic                                  load_timeout
);

  localparam int ROW_W  = $clog2(SYSTOLIC_SIZE);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(SYSTOLIC_SIZE - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  logic [1:0]                state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic                      load_ok_q, load_ok_d;
  logic                      load_timeout_q, load_timeout_d;

  logic                      last_row;

  assign last_row = (row_q == LAST_ROW);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    wait_d         = wait_q;
    base_d         = base_q;
    load_ok_d      = load_ok_q;
    load_timeout_d = load_timeout_q;
    load_done      = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (load_req) begin
          base_d         = tile_base;
          load_ok_d      = 1'b0;
          load_timeout_d = 1'b0;
          state_d        = LD_START;
        end
      end
      LD_START: begin
        row_d   = '0;
        wait_d  = '0;
        state_d = LD_SEND;
      end
      LD_SEND: begin
        // The allocator expects an unbroken run of rows, so SEND never stalls.
        if (last_row) begin
          state_d = LD_WAIT;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      LD_WAIT: begin
        if (recovery_done) begin
          load_ok_d = recovery_success;
          load_done = 1'b1;
          state_d   = LD_IDLE;
        end else if (wait_q == WAIT_MAX) begin
          load_timeout_d = 1'b1;
          load_ok_d      = 1'b0;
          load_done      = 1'b1;
          state_d        = LD_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = LD_IDLE;
    endcase

    // Abort overrides every transition above: drop the load silently and
    // leave the status of the previous load untouched.
    if (abort && (state_q != LD_IDLE)) begin
      state_d        = LD_IDLE;
      load_ok_d      = load_ok_q;
      load_timeout_d = load_timeout_q;
      load_done      = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LD_IDLE;
      row_q          <= '0;
      wait_q         <= '0;
      base_q         <= '0;
      load_ok_q      <= 1'b0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      wait_q         <= wait_d;
      base_q         <= base_d;
      load_ok_q      <= load_ok_d;
      load_timeout_q <= load_timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset clears them at once)
  // --------------------------------------------------------------------------
  // Reads run one row ahead of SEND to cover the SRAM latency: START fetches
  // row 0, SEND cycle k fetches row k+1, and the final SEND cycle reads nothing.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    if (state_q == LD_START) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = base_q;
    end else if ((state_q == LD_SEND) && !last_row) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = base_q + MEM_ADDR_WIDTH'(row_q) + MEM_ADDR_WIDTH'(1);
    end
  end

  assign weight_start = (state_q == LD_START);
  assign weight_valid = (state_q == LD_SEND);
  assign weights      = weight_valid ? mem_rd_data : '0;
  assign busy         = (state_q != LD_IDLE);
  assign load_ok      = load_ok_q;
  assign load_timeout = load_timeout_q;

endmodule : bisr_weight_loader
`default_nettype wire
